// File: rtl/fsm_calculadora_param.sv
// fsm_calculadora_param: keypad calculator control FSM.
//   Accumulates multi-digit decimal operands into binary registers, latches
//   an add/subtract operator, computes the signed result on "equal" and emits
//   one-cycle strobes to the datapath and display.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   tecla_valida    key-present level from the scanner (edge detected here)
//   tecla_pre       key code: 0-9 digit, A add, B equal, C clear, D subtract
//   numero1/2       operands, unsigned binary
//   operacion       latched operator (0 add, 1 subtract)
//   resultado       signed W+1-bit result
//   cargar_numero1/2, igual, rst_datos   one-cycle strobes
//   desborde        sticky: a digit was rejected because the operand was full
//   estado          00 NUM1, 01 NUM2, 10 RESULT
//   conteo          digits entered in the current operand
module fsm_calculadora_param #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned W      = 14,
    localparam int unsigned CW    = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tecla_valida,
    input  logic [3:0]    tecla_pre,
    output logic [W-1:0]  numero1,
    output logic [W-1:0]  numero2,
    output logic          operacion,
    output logic [W:0]    resultado,
    output logic          cargar_numero1,
    output logic          cargar_numero2,
    output logic          igual,
    output logic          rst_datos,
    output logic          desborde,
    output logic [1:0]    estado,
    output logic [CW-1:0] conteo
);

    typedef enum logic [1:0] {
        StNum1   = 2'b00,
        StNum2   = 2'b01,
        StResult = 2'b10
    } estado_e;

    localparam logic [3:0] KeyAdd = 4'hA;
    localparam logic [3:0] KeyEq  = 4'hB;
    localparam logic [3:0] KeyClr = 4'hC;
    localparam logic [3:0] KeySub = 4'hD;

    estado_e       estado_q, estado_d;
    logic          tecla_q, tecla_d;
    logic [W-1:0]  numero1_q, numero1_d;
    logic [W-1:0]  numero2_q, numero2_d;
    logic          operacion_q, operacion_d;
    logic [W:0]    resultado_q, resultado_d;
    logic          cargar1_q, cargar1_d;
    logic          cargar2_q, cargar2_d;
    logic          igual_q, igual_d;
    logic          rst_datos_q, rst_datos_d;
    logic          desborde_q, desborde_d;
    logic [CW-1:0] conteo_q, conteo_d;

    logic          evento;
    logic          es_digito;
    logic          es_oper;
    logic          lleno;
    logic [W-1:0]  acum1, acum2;
    logic [W:0]    suma, resta;

    assign evento    = tecla_valida && !tecla_q;
    assign es_digito = (tecla_pre <= 4'd9);
    assign es_oper   = (tecla_pre == KeyAdd) || (tecla_pre == KeySub);
    assign lleno     = (conteo_q >= CW'(DIGITS));

    // Accumulate in W+4 bits; the W/DIGITS constraint makes the truncation lossless.
    assign acum1 = W'((W+4)'(numero1_q) * (W+4)'(10) + (W+4)'(tecla_pre));
    assign acum2 = W'((W+4)'(numero2_q) * (W+4)'(10) + (W+4)'(tecla_pre));

    assign suma  = {1'b0, numero1_q} + {1'b0, numero2_q};
    assign resta = {1'b0, numero1_q} - {1'b0, numero2_q};

    always_comb begin
        estado_d    = estado_q;
        tecla_d     = tecla_valida;
        numero1_d   = numero1_q;
        numero2_d   = numero2_q;
        operacion_d = operacion_q;
        resultado_d = resultado_q;
        desborde_d  = desborde_q;
        conteo_d    = conteo_q;
        cargar1_d   = 1'b0;
        cargar2_d   = 1'b0;
        igual_d     = 1'b0;
        rst_datos_d = 1'b0;

        if (evento) begin
            if (tecla_pre == KeyClr) begin
                numero1_d   = '0;
                numero2_d   = '0;
                resultado_d = '0;
                operacion_d = 1'b0;
                conteo_d    = '0;
                desborde_d  = 1'b0;
                rst_datos_d = 1'b1;
                estado_d    = StNum1;
            end else begin
                unique case (estado_q)
                    StNum1: begin
                        if (es_digito) begin
                            if (lleno) begin
                                desborde_d = 1'b1;
                            end else begin
                                numero1_d = acum1;
                                conteo_d  = conteo_q + 1'b1;
                                cargar1_d = 1'b1;
                            end
                        end else if (es_oper) begin
                            operacion_d = (tecla_pre == KeySub);
                            numero2_d   = '0;
                            conteo_d    = '0;
                            estado_d    = StNum2;
                        end
                    end
                    StNum2: begin
                        if (es_digito) begin
                            if (lleno) begin
                                desborde_d = 1'b1;
                            end else begin
                                numero2_d = acum2;
                                conteo_d  = conteo_q + 1'b1;
                                cargar2_d = 1'b1;
                            end
                        end else if (es_oper) begin
                            // Operator may be changed only before any operand-2 digit.
                            if (conteo_q == '0) begin
                                operacion_d = (tecla_pre == KeySub);
                            end
                        end else if (tecla_pre == KeyEq) begin
                            resultado_d = operacion_q ? resta : suma;
                            igual_d     = 1'b1;
                            estado_d    = StResult;
                        end
                    end
                    StResult: begin
                        // A digit starts a fresh calculation; resultado stays on display.
                        if (es_digito) begin
                            numero1_d = W'(tecla_pre);
                            numero2_d = '0;
                            conteo_d  = CW'(1);
                            cargar1_d = 1'b1;
                            estado_d  = StNum1;
                        end
                    end
                    default: estado_d = StNum1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= StNum1;
            tecla_q     <= 1'b0;
            numero1_q   <= '0;
            numero2_q   <= '0;
            operacion_q <= 1'b0;
            resultado_q <= '0;
            cargar1_q   <= 1'b0;
            cargar2_q   <= 1'b0;
            igual_q     <= 1'b0;
            rst_datos_q <= 1'b0;
            desborde_q  <= 1'b0;
            conteo_q    <= '0;
        end else begin
            estado_q    <= estado_d;
            tecla_q     <= tecla_d;
            numero1_q   <= numero1_d;
            numero2_q   <= numero2_d;
            operacion_q <= operacion_d;
            resultado_q <= resultado_d;
            cargar1_q   <= cargar1_d;
            cargar2_q   <= cargar2_d;
            igual_q     <= igual_d;
            rst_datos_q <= rst_datos_d;
            desborde_q  <= desborde_d;
            conteo_q    <= conteo_d;
        end
    end

    assign numero1        = numero1_q;
    assign numero2        = numero2_q;
    assign operacion      = operacion_q;
    assign resultado      = resultado_q;
    assign cargar_numero1 = cargar1_q;
    assign cargar_numero2 = cargar2_q;
    assign igual          = igual_q;
    assign rst_datos      = rst_datos_q;
    assign desborde       = desborde_q;
    assign estado         = estado_q;
    assign conteo         = conteo_q;

endmodule
